score_box_plotter: RTL and testbench

SCORE_BOX_PLOTTER -- requirements
Module: score_box_plotter

---
 rtl/score_box_plotter_if.sv | 27 ++
 rtl/score_box_plotter.sv | 151 +++++++++++++++
 tb/tb_score_box_plotter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/score_box_plotter_if.sv
// Command and pixel handshake bundle for the score box plotter.
// The master side issues sweep commands and accepts pixels; the slave side is the plotter.
interface score_box_plotter_if;
    logic       start;
    logic       abort;
    logic       mode;
    logic [1:0] sel;
    logic [5:0] count;
    logic [2:0] fill_colour;
    logic       plot_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, mode, sel, count, fill_colour, plot_ready,
        input  x, y, colour, plot_valid, busy, done
    );

    modport slave (
        input  start, abort, mode, sel, count, fill_colour, plot_ready,
        output x, y, colour, plot_valid, busy, done
    );
endinterface

// File: rtl/score_box_plotter.sv
// Sweeps the 33-box score column of one or all players, emitting one pixel per
// accepted beat with either a clear colour or a partial score fill.
module score_box_plotter #(
    parameter int          NUM_PLAYERS  = 2,
    parameter int          X_BASE       = 38,
    parameter int          X_STRIDE     = 80,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b111
) (
    input  logic                 clk,
    input  logic                 reset,
    score_box_plotter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] player_q, player_d;
    logic [5:0] idx_q, idx_d;
    logic       mode_q, mode_d;
    logic [5:0] count_q, count_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load_pixel;
    logic       last_beat;

    // Interleaved box heights: left column holds 17 boxes, right column 16.
    function automatic logic [6:0] box_y(input logic [5:0] idx);
        case (idx)
            6'd0:  box_y = 7'd4;   6'd1:  box_y = 7'd13;  6'd2:  box_y = 7'd19;
            6'd3:  box_y = 7'd22;  6'd4:  box_y = 7'd25;  6'd5:  box_y = 7'd31;
            6'd6:  box_y = 7'd37;  6'd7:  box_y = 7'd49;  6'd8:  box_y = 7'd58;
            6'd9:  box_y = 7'd61;  6'd10: box_y = 7'd67;  6'd11: box_y = 7'd76;
            6'd12: box_y = 7'd82;  6'd13: box_y = 7'd85;  6'd14: box_y = 7'd88;
            6'd15: box_y = 7'd94;  6'd16: box_y = 7'd97;
            6'd17: box_y = 7'd7;   6'd18: box_y = 7'd10;  6'd19: box_y = 7'd16;
            6'd20: box_y = 7'd28;  6'd21: box_y = 7'd34;  6'd22: box_y = 7'd40;
            6'd23: box_y = 7'd43;  6'd24: box_y = 7'd46;  6'd25: box_y = 7'd52;
            6'd26: box_y = 7'd55;  6'd27: box_y = 7'd64;  6'd28: box_y = 7'd70;
            6'd29: box_y = 7'd73;  6'd30: box_y = 7'd79;  6'd31: box_y = 7'd91;
            6'd32: box_y = 7'd100;
            default: box_y = 7'd0;
        endcase
    endfunction

    assign last_beat = (idx_q == 6'd32) &&
                       (mode_q || (int'(player_q) == NUM_PLAYERS - 1));

    always_comb begin
        state_d    = state_q;
        player_d   = player_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        count_d    = count_q;
        fill_d     = fill_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_pixel = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && (!bus.mode || (int'(bus.sel) < NUM_PLAYERS))) begin
                    state_d    = RUN;
                    mode_d     = bus.mode;
                    count_d    = (bus.count > 6'd33) ? 6'd33 : bus.count;
                    fill_d     = bus.fill_colour;
                    player_d   = bus.mode ? bus.sel : 2'd0;
                    idx_d      = 6'd0;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    load_pixel = 1'b1;
                end
            end
            RUN: begin
                // Abort wins even if the current beat is being accepted.
                if (bus.abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (valid_q && bus.plot_ready) begin
                    if (last_beat) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (idx_q == 6'd32) begin
                            idx_d    = 6'd0;
                            player_d = player_q + 2'd1;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                        load_pixel = 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load_pixel) begin
            x_d      = 8'(X_BASE + X_STRIDE * int'(player_d) + ((idx_d >= 6'd17) ? 5 : 0));
            y_d      = box_y(idx_d);
            colour_d = (mode_d && (idx_d < count_d)) ? fill_d : CLEAR_COLOUR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            player_q <= 2'd0;
            idx_q    <= 6'd0;
            mode_q   <= 1'b0;
            count_q  <= 6'd0;
            fill_q   <= 3'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            fill_q   <= fill_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.plot_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_score_box_plotter.sv
// Directed bench for score_box_plotter: table of sweeps with spot values, a
// reference box map for full-sequence comparison, and abort/reset sequences.
module tb_score_box_plotter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    score_box_plotter_if bus();

    score_box_plotter #(
        .NUM_PLAYERS(2), .X_BASE(38), .X_STRIDE(80), .CLEAR_COLOUR(3'b111)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    int ly[17] = '{4, 13, 19, 22, 25, 31, 37, 49, 58, 61, 67, 76, 82, 85, 88, 94, 97};
    int ry[16] = '{7, 10, 16, 28, 34, 40, 43, 46, 52, 55, 64, 70, 73, 79, 91, 100};

    int bx[128];
    int by[128];
    int bc[128];
    int nb;

    typedef struct {
        logic       m;
        logic [1:0] s;
        logic [5:0] cnt;
        logic [2:0] f;
        bit         tog;
        int         sb;
        int         sx;
        int         sy;
        int         sc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void exp_beat(input logic m, input int s, input int cnt, input int f,
                                     input int i, output int ex, output int ey, output int ec);
        int p, j, c;
        p  = m ? s : i / 33;
        j  = m ? i : i % 33;
        c  = (cnt > 33) ? 33 : cnt;
        ex = 38 + 80 * p + ((j >= 17) ? 5 : 0);
        ey = (j < 17) ? ly[j] : ry[j - 17];
        ec = (m && j < c) ? f : 7;
    endfunction

    task automatic do_sweep(input logic m, input logic [1:0] s, input logic [5:0] cnt,
                            input logic [2:0] f, input bit tog);
        int last_cyc, done_cyc, bad, seq_bad, first_bad, ex, ey, ec;
        logic prev_hold;
        logic [7:0] hx;
        logic [6:0] hy;
        logic [2:0] hc;
        nb = 0; last_cyc = -1; done_cyc = -1; bad = 0; seq_bad = 0; first_bad = -1;
        prev_hold = 1'b0; hx = '0; hy = '0; hc = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.sel = s; bus.count = cnt; bus.fill_colour = f;
        bus.plot_ready = 1'b0;
        @(negedge clk);
        // Scramble the command inputs: the captured copy must drive the sweep.
        bus.start = 1'b0; bus.mode = ~m; bus.sel = ~s; bus.count = 6'd2; bus.fill_colour = ~f;
        chk("latency_valid", int'(bus.plot_valid), 1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (prev_hold && (bus.x != hx || bus.y != hy || bus.colour != hc)) bad++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.plot_valid != bus.busy) bad++;
            bus.start = (nb == 3);
            bus.plot_ready = tog ? (cyc % 2 == 0) : 1'b1;
            if (bus.plot_valid && bus.plot_ready) begin
                if (nb < 128) begin
                    bx[nb] = int'(bus.x); by[nb] = int'(bus.y); bc[nb] = int'(bus.colour);
                end
                nb++;
                last_cyc = cyc;
                prev_hold = 1'b0;
            end else begin
                prev_hold = bus.plot_valid;
                hx = bus.x; hy = bus.y; hc = bus.colour;
            end
            @(negedge clk);
        end
        bus.plot_ready = 1'b0;
        chk("beat_count", nb, m ? 33 : 66);
        chk("done_after_last_beat", done_cyc - last_cyc, 1);
        chk("busy_low_at_done", int'(bus.busy), 0);
        chk("valid_low_at_done", int'(bus.plot_valid), 0);
        chk("hold_and_busy_consistency", bad, 0);
        for (int i = 0; i < nb && i < 128; i++) begin
            exp_beat(m, int'(s), int'(cnt), int'(f), i, ex, ey, ec);
            if (bx[i] != ex || by[i] != ey || bc[i] != ec) begin
                seq_bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk($sformatf("sequence_mismatches first_bad_beat=%0d", first_bad), seq_bad, 0);
        // Start arriving in the DONE cycle must be dropped.
        bus.start = 1'b1; bus.mode = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_single_pulse", int'(bus.done), 0);
        chk("start_in_done_ignored", int'(bus.plot_valid), 0);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.sel = 2'd0;
        bus.count = 6'd0; bus.fill_colour = 3'd0; bus.plot_ready = 1'b0;

        tbl[0]  = '{1'b0, 2'd0, 6'd0,  3'd0, 1'b0, 0,  38,  4,   7};
        tbl[1]  = '{1'b0, 2'd0, 6'd0,  3'd0, 1'b0, 17, 43,  7,   7};
        tbl[2]  = '{1'b0, 2'd0, 6'd0,  3'd0, 1'b0, 33, 118, 4,   7};
        tbl[3]  = '{1'b0, 2'd0, 6'd0,  3'd0, 1'b0, 65, 123, 100, 7};
        tbl[4]  = '{1'b1, 2'd1, 6'd5,  3'd4, 1'b0, 4,  118, 25,  4};
        tbl[5]  = '{1'b1, 2'd1, 6'd5,  3'd4, 1'b0, 5,  118, 31,  7};
        tbl[6]  = '{1'b0, 2'd0, 6'd0,  3'd0, 1'b1, 40, 118, 49,  7};
        tbl[7]  = '{1'b1, 2'd0, 6'd0,  3'd3, 1'b0, 0,  38,  4,   7};
        tbl[8]  = '{1'b1, 2'd0, 6'd40, 3'd2, 1'b0, 32, 43,  100, 2};
        tbl[9]  = '{1'b1, 2'd1, 6'd33, 3'd5, 1'b1, 32, 123, 100, 5};
        tbl[10] = '{1'b1, 2'd0, 6'd17, 3'd1, 1'b0, 16, 38,  97,  1};
        tbl[11] = '{1'b1, 2'd0, 6'd17, 3'd1, 1'b0, 17, 43,  7,   7};

        // Asynchronous reset with no clock edge in between.
        #2 reset = 1'b1;
        #1;
        chk("reset_outputs_zero", int'({bus.x, bus.y, bus.colour, bus.plot_valid, bus.busy, bus.done}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_sweep(tbl[i].m, tbl[i].s, tbl[i].cnt, tbl[i].f, tbl[i].tog);
            chk($sformatf("vec%0d_x", i), bx[tbl[i].sb], tbl[i].sx);
            chk($sformatf("vec%0d_y", i), by[tbl[i].sb], tbl[i].sy);
            chk($sformatf("vec%0d_colour", i), bc[tbl[i].sb], tbl[i].sc);
        end

        // Abort while idle is ignored; abort at beat 10 with ready high cancels.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.abort = 1'b1; bus.plot_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abort_in_idle_ignored", int'(bus.plot_valid), 1);
        repeat (10) @(negedge clk);
        chk("abort_beat10_y", int'(bus.y), 67);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_valid_low", int'(bus.plot_valid), 0);
        chk("abort_busy_low", int'(bus.busy), 0);
        seen = 0;
        repeat (4) begin
            seen += int'(bus.done);
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        do_sweep(1'b0, 2'd0, 6'd0, 3'd0, 1'b0);
        chk("restart_after_abort_x", bx[0], 38);
        chk("restart_after_abort_y", by[0], 4);

        // Reset mid-sweep at beat 20.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.plot_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("beat20_x", int'(bus.x), 43);
        #1 reset = 1'b1;
        #1;
        chk("midsweep_reset_zero", int'({bus.x, bus.y, bus.colour, bus.plot_valid, bus.busy, bus.done}), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(bus.done) + int'(bus.plot_valid);
        end
        chk("post_reset_quiet", seen, 0);

        // Out-of-range player selections in mode 1 never start a sweep.
        for (int k = 2; k < 4; k++) begin
            bus.start = 1'b1; bus.mode = 1'b1; bus.sel = 2'(k);
            @(negedge clk);
            bus.start = 1'b0;
            seen = int'(bus.busy) + int'(bus.plot_valid);
            @(negedge clk);
            seen += int'(bus.busy) + int'(bus.done);
            chk($sformatf("sel%0d_ignored", k), seen, 0);
        end
        do_sweep(1'b0, 2'd0, 6'd0, 3'd0, 1'b1);
        chk("fresh_after_reset_x", bx[0], 38);
        chk("fresh_after_reset_y", by[0], 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
